// File: rtl/seg_write_sequencer_if.sv
// Request/grant and display write-port bundle for the segment write sequencer.
interface seg_write_sequencer_if;
  logic        req0;
  logic [31:0] data0;
  logic        ack0;
  logic        req1;
  logic [31:0] data1;
  logic        ack1;
  logic [3:0]  num;
  logic [2:0]  sel;
  logic        wr;
  logic        busy;

  // Requester / observer side
  modport master (
    output req0, data0, req1, data1,
    input  ack0, ack1, num, sel, wr, busy
  );

  // Sequencer side
  modport slave (
    input  req0, data0, req1, data1,
    output ack0, ack1, num, sel, wr, busy
  );
endinterface

// File: rtl/seg_write_sequencer.sv
// Round-robin write scheduler feeding an 8-digit seven-segment display port.
// Latches one 32-bit image per grant and writes digits 0..7 in order, with
// GAP idle cycles between consecutive digit writes. All outputs registered.
module seg_write_sequencer #(
  parameter int unsigned GAP = 0
) (
  input  logic                 CLK,
  input  logic                 rst,
  seg_write_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, GAP_WAIT} state_t;

  // Final gap-counter value before moving on to the next digit.
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [2:0]  dig_q, dig_d;
  logic [3:0]  gap_q, gap_d;
  logic [31:0] shadow_q, shadow_d;
  logic [3:0]  num_q, num_d;
  logic [2:0]  sel_q, sel_d;
  logic        wr_q, wr_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        busy_q, busy_d;

  logic        gnt0, gnt1;
  logic [2:0]  dig_nxt;
  logic [3:0]  nib_nxt;

  // Round robin: on a tie, requester 1 wins only if 0 was granted last.
  assign gnt1    = bus.req1 & (~bus.req0 | ~last_q);
  assign gnt0    = bus.req0 & ~gnt1;
  assign dig_nxt = dig_q + 3'd1;
  assign nib_nxt = shadow_q[{dig_nxt, 2'b00} +: 4];

  // State and registered outputs
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      dig_q    <= 3'd0;
      gap_q    <= 4'd0;
      shadow_q <= 32'd0;
      num_q    <= 4'd0;
      sel_q    <= 3'd0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      dig_q    <= dig_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      num_q    <= num_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
    end
  end

  // Next state: arbitration in IDLE, digit/gap sequencing otherwise
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    dig_d    = dig_q;
    gap_d    = gap_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          state_d  = WRITE;
          dig_d    = 3'd0;
          last_d   = gnt1;
          shadow_d = gnt1 ? bus.data1 : bus.data0;
        end
      end
      WRITE: begin
        if (dig_q == 3'd7) begin
          state_d = IDLE;
        end else if (GAP == 0) begin
          dig_d = dig_nxt;
        end else begin
          state_d = GAP_WAIT;
          gap_d   = 4'd0;
        end
      end
      GAP_WAIT: begin
        if (gap_q == GAP_LAST) begin
          state_d = WRITE;
          dig_d   = dig_nxt;
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values; sel/num hold between writes
  always_comb begin
    num_d  = num_q;
    sel_d  = sel_q;
    wr_d   = 1'b0;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    busy_d = busy_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (gnt0 | gnt1) begin
          // Digit 0 comes straight from the granted requester's data.
          ack0_d = gnt0;
          ack1_d = gnt1;
          wr_d   = 1'b1;
          sel_d  = 3'd0;
          num_d  = gnt1 ? bus.data1[3:0] : bus.data0[3:0];
          busy_d = 1'b1;
        end
      end
      WRITE: begin
        if (dig_q == 3'd7) begin
          busy_d = 1'b0;
        end else if (GAP == 0) begin
          wr_d  = 1'b1;
          sel_d = dig_nxt;
          num_d = nib_nxt;
        end
      end
      GAP_WAIT: begin
        if (gap_q == GAP_LAST) begin
          wr_d  = 1'b1;
          sel_d = dig_nxt;
          num_d = nib_nxt;
        end
      end
      default: busy_d = 1'b0;
    endcase
  end

  assign bus.num  = num_q;
  assign bus.sel  = sel_q;
  assign bus.wr   = wr_q;
  assign bus.ack0 = ack0_q;
  assign bus.ack1 = ack1_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_seg_write_sequencer.sv
// Directed bench for seg_write_sequencer: one GAP=0 and one GAP=2 instance,
// scoreboards of expected digit writes and grant order checked on negedges.
module tb_seg_write_sequencer;
  logic CLK = 1'b0;
  logic rst = 1'b0;
  always #5 CLK = ~CLK;

  seg_write_sequencer_if b0();
  seg_write_sequencer_if b2();

  seg_write_sequencer #(.GAP(0)) u0 (.CLK(CLK), .rst(rst), .bus(b0.slave));
  seg_write_sequencer #(.GAP(2)) u2 (.CLK(CLK), .rst(rst), .bus(b2.slave));

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] wq0[$];  // expected {sel,num} per write, GAP=0 instance
  logic [6:0] wq2[$];  // same, GAP=2 instance
  int         aq0[$];  // expected grant order (0/1)
  int         aq2[$];
  logic       pa0 = 1'b0, pa2 = 1'b0;  // any ack in previous cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push0(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) wq0.push_back({3'(i), d[4*i +: 4]});
  endtask

  task automatic push2(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) wq2.push_back({3'(i), d[4*i +: 4]});
  endtask

  task automatic clr_reqs();
    b0.req0 = 1'b0; b0.req1 = 1'b0; b2.req0 = 1'b0; b2.req1 = 1'b0;
  endtask

  task automatic do_reset();
    clr_reqs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while ((b0.busy || b2.busy) && c < 100) begin
      tick();
      c++;
    end
    chk(tag, {31'd0, b0.busy | b2.busy}, 32'd0);
  endtask

  // Scoreboard monitor, GAP=0 instance
  always @(negedge CLK) begin : mon0
    logic [6:0] e;
    int         a;
    if (b0.wr) begin
      if (wq0.size() == 0) chk("u0_wr_unexpected", {25'd0, b0.sel, b0.num}, 32'h7f00);
      else begin
        e = wq0.pop_front();
        chk("u0_wr", {25'd0, b0.sel, b0.num}, {25'd0, e});
      end
    end
    if (b0.ack0 | b0.ack1) begin
      chk("u0_ack_excl", {31'd0, b0.ack0 & b0.ack1}, 32'd0);
      chk("u0_ack_pulse", {31'd0, pa0}, 32'd0);
      a = (aq0.size() == 0) ? 9 : aq0.pop_front();
      chk("u0_ack_order", {31'd0, b0.ack1}, a);
    end
    pa0 <= b0.ack0 | b0.ack1;
  end

  // Scoreboard monitor, GAP=2 instance
  always @(negedge CLK) begin : mon2
    logic [6:0] e;
    int         a;
    if (b2.wr) begin
      if (wq2.size() == 0) chk("u2_wr_unexpected", {25'd0, b2.sel, b2.num}, 32'h7f00);
      else begin
        e = wq2.pop_front();
        chk("u2_wr", {25'd0, b2.sel, b2.num}, {25'd0, e});
      end
    end
    if (b2.ack0 | b2.ack1) begin
      chk("u2_ack_excl", {31'd0, b2.ack0 & b2.ack1}, 32'd0);
      chk("u2_ack_pulse", {31'd0, pa2}, 32'd0);
      a = (aq2.size() == 0) ? 9 : aq2.pop_front();
      chk("u2_ack_order", {31'd0, b2.ack1}, a);
    end
    pa2 <= b2.ack0 | b2.ack1;
  end

  initial begin
    int cnt;
    int n;
    logic [2:0] es;
    logic [31:0] d;
    clr_reqs();
    b0.data0 = '0; b0.data1 = '0; b2.data0 = '0; b2.data1 = '0;
    repeat (2) tick();
    // Reset state
    chk("rst_u0", {20'd0, b0.num, b0.sel, b0.wr, b0.ack0, b0.ack1, b0.busy}, 32'd0);
    chk("rst_u2", {20'd0, b2.num, b2.sel, b2.wr, b2.ack0, b2.ack1, b2.busy}, 32'd0);
    rst = 1'b1;
    tick();

    // Single request, GAP=0
    b0.data0 = 32'h7654_3210; b0.req0 = 1'b1;
    aq0.push_back(0); push0(32'h7654_3210, 8);
    tick();  // cycle N+1
    chk("t1_ack0", {31'd0, b0.ack0}, 32'd1);
    chk("t1_dig0", {24'd0, b0.wr, b0.sel, b0.num}, {24'd0, 1'b1, 3'd0, 4'd0});
    b0.req0 = 1'b0;
    tick();
    chk("t1_ack0_one_cycle", {31'd0, b0.ack0}, 32'd0);
    cnt = 2;
    while (b0.busy && cnt < 30) begin tick(); cnt++; end
    chk("t1_busy_fall_cycle", cnt, 32'd9);

    // Tie after reset: 0 first, then 1 after one idle cycle
    do_reset();
    b0.data0 = 32'h1111_1111; b0.data1 = 32'h2EE1_2052;
    aq0.push_back(0); aq0.push_back(1);
    push0(32'h1111_1111, 8); push0(32'h2EE1_2052, 8);
    b0.req0 = 1'b1; b0.req1 = 1'b1;
    tick();  // cycle N+1
    chk("t2_ack0_first", {30'd0, b0.ack0, b0.ack1}, 32'd2);
    b0.req0 = 1'b0;
    cnt = 1;
    while (!b0.ack1 && cnt < 30) begin
      tick(); cnt++;
      if (cnt == 9) chk("t2_idle_cycle", {30'd0, b0.wr, b0.busy}, 32'd0);
    end
    chk("t2_ack1_cycle", cnt, 32'd10);
    b0.req1 = 1'b0;
    wait_idle("t2_done");

    // GAP=2, single request on port 1
    do_reset();
    d = 32'hFEDC_BA98;
    b2.data1 = d; b2.req1 = 1'b1;
    aq2.push_back(1); push2(d, 8);
    for (int c = 1; c <= 23; c++) begin
      if (c > 1) tick(); else tick();
      if (c == 1) b2.req1 = 1'b0;
      es = ((c - 1) / 3 > 7) ? 3'd7 : 3'((c - 1) / 3);
      chk($sformatf("t3_c%0d", c), {23'd0, b2.wr, b2.busy, b2.sel, b2.num},
          {23'd0, (c <= 22) && ((c - 1) % 3 == 0), (c <= 22), es, d[4*es +: 4]});
    end

    // Continuous tie: strict alternation 0,1,0,1
    do_reset();
    b0.data0 = 32'hA5A5_0F0F; b0.data1 = 32'h3C3C_9696;
    for (int k = 0; k < 4; k++) begin
      aq0.push_back(k % 2);
      push0((k % 2) ? 32'h3C3C_9696 : 32'hA5A5_0F0F, 8);
    end
    b0.req0 = 1'b1; b0.req1 = 1'b1;
    n = 0; cnt = 0;
    while (n < 4 && cnt < 80) begin
      tick(); cnt++;
      if (b0.ack0 | b0.ack1) n++;
    end
    b0.req0 = 1'b0; b0.req1 = 1'b0;
    chk("t4_ack_count", n, 32'd4);
    chk("t4_fourth_ack_cycle", cnt, 32'd28);
    wait_idle("t4_done");

    // Reset during the digit-3 write, then restart on port 1
    do_reset();
    b0.data0 = 32'h8765_4321; b0.req0 = 1'b1;
    aq0.push_back(0); push0(32'h8765_4321, 3);
    tick();
    b0.req0 = 1'b0;
    repeat (3) tick();  // cycle N+4: digit 3
    chk("t5_dig3", {24'd0, b0.wr, b0.sel, b0.num}, {24'd0, 1'b1, 3'd3, 4'd4});
    rst = 1'b0;
    #1;
    chk("t5_async_rst", {20'd0, b0.num, b0.sel, b0.wr, b0.ack0, b0.ack1, b0.busy}, 32'd0);
    repeat (2) tick();
    b0.data1 = 32'h0ABC_DEF5; b0.req1 = 1'b1;
    aq0.push_back(1); push0(32'h0ABC_DEF5, 8);
    rst = 1'b1;
    tick();
    chk("t5_restart", {25'd0, b0.ack1, b0.wr, b0.sel, b0.num}, {25'd0, 1'b1, 1'b1, 3'd0, 4'd5});
    b0.req1 = 1'b0;
    wait_idle("t5_done");

    // Data change after ack is ignored
    do_reset();
    b0.data0 = 32'h0000_0000; b0.req0 = 1'b1;
    aq0.push_back(0); push0(32'h0000_0000, 8);
    tick();
    chk("t6_ack0", {31'd0, b0.ack0}, 32'd1);
    b0.data0 = 32'hFFFF_FFFF; b0.req0 = 1'b0;
    wait_idle("t6_done");
    repeat (2) tick();

    chk("sb_wr_drained", wq0.size() + wq2.size(), 32'd0);
    chk("sb_ack_drained", aq0.size() + aq2.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
